// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the write port of one synchronous FIFO among NUM_REQ producers.
// Ownership is handed out round-robin in bursts of at most BURST_MAX words.
// Every tenure is separated by exactly one IDLE arbitration cycle. No write
// is issued while the FIFO reports full. The block also watches the FIFO's
// write-acknowledge and overflow flags and raises sticky error bits.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   req             per-requester valid, held with stable data until granted
//   req_data        requester i's word at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt             one-hot accept; a word moves on an edge with req[i] && gnt[i]
//   fifo_wr_en      FIFO write enable (combinational, same cycle as gnt)
//   fifo_data_in    owner's req_data slice
//   fifo_full       FIFO full flag, gates the grant in the current cycle
//   fifo_wr_ack     FIFO write acknowledge, expected one cycle after a write
//   fifo_overflow   FIFO overflow flag
//   busy            a tenure is in progress (state == BURST)
//   owner           current or most recent owner index
//   wr_count        total accepted words, 16-bit wrapping
//   ack_err         sticky: a write was not acknowledged
//   ovf_err         sticky: the FIFO reported overflow
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int BURST_MAX  = 4,
  localparam int OWN_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic [OWN_W-1:0]              owner,
  output logic [15:0]                   wr_count,
  output logic                          ack_err,
  output logic                          ovf_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int               CNT_W    = $clog2(BURST_MAX + 1);
  // burst_cnt value at which the next transfer completes the tenure.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  state_t             state;
  logic [OWN_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   burst_cnt;
  logic               wr_en_d;

  logic [OWN_W-1:0]   pick;
  logic [OWN_W-1:0]   idx;

  // ---------------------------------------------------------------------------
  // Grant and write-port mux: purely combinational from req, state, owner and
  // the current fifo_full, so a full FIFO blocks the write in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every bit first so no path leaves gnt unassigned (no latch).
    gnt = '0;
    if (state == BURST && !fifo_full) begin
      gnt[owner] = req[owner];
    end
  end

  assign fifo_wr_en   = |(req & gnt);
  assign fifo_data_in = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
  assign busy         = (state == BURST);

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requester at or after rr_ptr. Scanning from the
  // far end down lets the nearest active requester win. The index addition
  // wraps naturally because NUM_REQ is a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick = rr_ptr;
    idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + OWN_W'(k);
      if (req[idx]) begin
        pick = idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, counters and error monitors.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      wr_en_d   <= 1'b0;
      wr_count  <= '0;
      ack_err   <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_en_d <= fifo_wr_en;

      // The FIFO acknowledges one cycle after each write; a missing ack is
      // latched until reset.
      if (wr_en_d && !fifo_wr_ack) begin
        ack_err <= 1'b1;
      end
      if (fifo_overflow) begin
        ovf_err <= 1'b1;
      end

      if (fifo_wr_en) begin
        wr_count <= wr_count + 16'd1;
      end

      unique case (state)
        IDLE: begin
          if (|req) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end

        BURST: begin
          // A dropped request ends the tenure even while stalled on full.
          if (!req[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner + 1'b1;
          end else if (fifo_wr_en) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == CNT_LAST) begin
              state  <= IDLE;
              rr_ptr <= owner + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
